memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares the single memory command port between instruction fetch (read-only) and the memory stage (load/store).
- Accepts one request at a time, forwards it to memory, and routes read data back to the port that issued it.
- Sits between the fetch/memory pipeline stages and the memory model.
- Uses the existing 3-bit memory command encoding: NOP, READ, WRITE.

Parameters:
- ROUND_ROBIN, 1. When 1, alternate the grant on ties. When 0, the data port always wins ties.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_cmd  in  3  instruction-port command; only NOP or READ are legal
- i_cmd_ready  out  1  instruction command accepted this cycle when i_cmd!=NOP
- i_addr  in  32  instruction fetch address
- i_rdata  out  32  instruction read data
- i_rdata_valid  out  1  one-cycle pulse: i_rdata is valid
- d_cmd  in  3  data-port command: NOP, READ or WRITE
- d_cmd_ready  out  1  data command accepted this cycle when d_cmd!=NOP
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_wmask  in  32  store byte-lane mask
- d_rdata  out  32  load data
- d_rdata_valid  out  1  one-cycle pulse: d_rdata is valid
- mem_cmd  out  3  command to memory
- mem_cmd_ready  in  1  memory accepts mem_cmd this cycle
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wmask  out  32  memory write mask
- mem_rdata  in  32  memory read data
- mem_rdata_valid  in  1  mem_rdata is valid this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - state=IDLE.
  - owner=INST; last_grant=INST, so the first tie goes to data.
  - i_rdata_valid=0 and d_rdata_valid=0.
  - i_rdata=0 and d_rdata=0.
  - mem_cmd=NOP (combinational from state).
- i_cmd=WRITE is treated as NOP and is never granted.
- IDLE state:
  - A port requests when its cmd!=NOP.
  - Grant:
    - Only one port requests: grant that port.
    - Both request: with ROUND_ROBIN=1, grant the port that is not last_grant; with ROUND_ROBIN=0, grant data.
  - x_cmd_ready is combinational: it is 1 only in IDLE and only for the granted port. With no requests, both ready outputs are 1.
  - On accept: latch cmd, addr, wdata, wmask and owner; update last_grant; go to ISSUE.
  - mem_cmd=NOP.
- ISSUE state:
  - mem_cmd, mem_addr, mem_wdata and mem_wmask are driven from the latched request.
  - Both x_cmd_ready=0.
  - If mem_cmd_ready=1, the transfer completes this cycle:
    - WRITE: go to IDLE. No completion pulse is generated for writes.
    - READ: go to WAIT_READ.
  - If mem_cmd_ready=0, hold all outputs stable and stay in ISSUE.
- WAIT_READ state:
  - mem_cmd=NOP.
  - When mem_rdata_valid=1: register mem_rdata into the owner's x_rdata, pulse the owner's x_rdata_valid for one cycle on the next cycle, and go to IDLE.
  - A new request may be accepted in the same cycle that x_rdata_valid is high.
- Latency (accept in cycle 0):
  - mem_cmd is driven in cycle 1.
  - A write with mem_cmd_ready=1 leaves IDLE free again in cycle 2.
  - A read whose mem_rdata_valid arrives in cycle N gives x_rdata_valid in cycle N+1.
- Data outputs: x_rdata holds its value after the valid pulse until the next read for the same port. The non-owner's rdata and valid are untouched.
- mem_rdata_valid in IDLE or ISSUE is ignored and causes no valid pulse.
- Reset mid-operation: the pending request is discarded and the state returns to IDLE. A stale mem_rdata_valid arriving after reset is ignored.
- Simultaneous events: reset has priority over everything, including a completion in the same cycle.

Decomposition:
- Shared package memory_const: MEMORY_CMD_NOP=0, MEMORY_CMD_READ=1, MEMORY_CMD_WRITE=2.
- Local state encodings: IDLE, ISSUE, WAIT_READ. Port-id constants INST=0, DATA=1.
- One sub-module is natural: arb_grant2, a combinational 2-way grant computed from the two requests, last_grant and ROUND_ROBIN. Everything else stays in memory_arbiter.

Test Plan:
1. Data store to addr 0x100, wdata 0xDEADBEEF, wmask 0x000000FF, mem_cmd_ready=1 -> mem_cmd=WRITE for exactly one cycle with those values, no rdata_valid pulse, back in IDLE two cycles after accept.
2. Instruction read of 0x0 with memory returning 0x00000013 three cycles after issue -> i_rdata=0x00000013 and i_rdata_valid high for one cycle; d_rdata_valid stays 0.
3. Both ports request in the same cycle after reset, ROUND_ROBIN=1 -> data granted first; both requesting again -> instruction granted; with ROUND_ROBIN=0 data wins both times.
4. mem_cmd_ready held at 0 for 5 cycles while in ISSUE -> mem_cmd, mem_addr, mem_wdata and mem_wmask stay stable; both x_cmd_ready=0; the transfer completes in the cycle ready rises.
5. Reset asserted while in WAIT_READ, then mem_rdata_valid arrives -> no x_rdata_valid pulse, state IDLE, both x_cmd_ready=1.
6. i_cmd=WRITE with no data request -> i_cmd_ready=1, no grant, mem_cmd stays NOP.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared memory command encoding plus arbiter-local states and port ids
package memory_const;
  localparam logic [2:0] MEMORY_CMD_NOP   = 3'd0;
  localparam logic [2:0] MEMORY_CMD_READ  = 3'd1;
  localparam logic [2:0] MEMORY_CMD_WRITE = 3'd2;
endpackage

package memory_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_READ} state_t;
  typedef enum logic {INST = 1'b0, DATA = 1'b1} port_t;
endpackage

// File: rtl/memory_arbiter_arb_grant2.sv
// arb_grant2: combinational two-way grant between instruction and data requests
module arb_grant2
  import memory_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic  i_req,
  input  logic  d_req,
  input  port_t last_grant,
  output port_t grant
);
  always_comb
    grant = (i_req && d_req) ? (ROUND_ROBIN ? (last_grant == INST ? DATA : INST) : DATA)
                             : (d_req ? DATA : INST);
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory command port between instruction fetch and the data stage
module memory_arbiter
  import memory_const::*;
  import memory_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  i_cmd,
  output logic        i_cmd_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_rdata_valid,
  input  logic [2:0]  d_cmd,
  output logic        d_cmd_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_rdata_valid,
  output logic [2:0]  mem_cmd,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid
);
  state_t      state, state_n;
  port_t       owner, last_grant, grant;
  logic [2:0]  cmd_q;
  logic [31:0] addr_q, wdata_q, wmask_q;
  logic        i_req, d_req, any_req, accept;

  arb_grant2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_grant (
    .i_req(i_req),
    .d_req(d_req),
    .last_grant(last_grant),
    .grant(grant)
  );

  // instruction writes are illegal and simply never count as a request
  always_comb begin
    i_req       = i_cmd == MEMORY_CMD_READ;
    d_req       = d_cmd != MEMORY_CMD_NOP;
    any_req     = i_req || d_req;
    accept      = state == IDLE && any_req;
    i_cmd_ready = state == IDLE && (!any_req || grant == INST);
    d_cmd_ready = state == IDLE && (!any_req || grant == DATA);
    mem_cmd     = state == ISSUE ? cmd_q : MEMORY_CMD_NOP;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    mem_wmask   = wmask_q;
    state_n     = state == IDLE      ? (accept ? ISSUE : IDLE) :
                  state == ISSUE     ? (!mem_cmd_ready ? ISSUE :
                                        cmd_q == MEMORY_CMD_WRITE ? IDLE : WAIT_READ) :
                  state == WAIT_READ ? (mem_rdata_valid ? IDLE : WAIT_READ) : IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= INST;
      last_grant    <= INST;
      cmd_q         <= MEMORY_CMD_NOP;
      addr_q        <= '0;
      wdata_q       <= '0;
      wmask_q       <= '0;
      i_rdata       <= '0;
      d_rdata       <= '0;
      i_rdata_valid <= 1'b0;
      d_rdata_valid <= 1'b0;
    end else begin
      state         <= state_n;
      i_rdata_valid <= 1'b0;
      d_rdata_valid <= 1'b0;
      if (accept) begin
        cmd_q      <= grant == DATA ? d_cmd : MEMORY_CMD_READ;
        addr_q     <= grant == DATA ? d_addr : i_addr;
        wdata_q    <= grant == DATA ? d_wdata : '0;
        wmask_q    <= grant == DATA ? d_wmask : '0;
        owner      <= grant;
        last_grant <= grant;
      end
      if (state == WAIT_READ && mem_rdata_valid) begin
        if (owner == DATA) begin
          d_rdata       <= mem_rdata;
          d_rdata_valid <= 1'b1;
        end else begin
          i_rdata       <= mem_rdata;
          i_rdata_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized transaction checks against a transaction-level model
module tb_memory_arbiter;
  import memory_const::*;
  logic        clk = 1'b0, reset;
  logic [2:0]  i_cmd, d_cmd, mem_cmd;
  logic        i_cmd_ready, d_cmd_ready, i_rdata_valid, d_rdata_valid;
  logic [31:0] i_addr, d_addr, d_wdata, d_wmask, i_rdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_wmask, mem_rdata;
  logic        mem_cmd_ready, mem_rdata_valid;
  logic [2:0]  i_cmd0, d_cmd0, mem_cmd0;
  logic        i_ready0, d_ready0, i_valid0, d_valid0;
  logic [31:0] i_rdata0, d_rdata0, mem_addr0, mem_wdata0, mem_wmask0;
  int          tests = 0, fails = 0;
  bit          last_win;
  logic [31:0] m_irdata, m_drdata;

  always #5 clk = ~clk;

  memory_arbiter #(.ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .i_cmd(i_cmd), .i_cmd_ready(i_cmd_ready), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid),
    .d_cmd(d_cmd), .d_cmd_ready(d_cmd_ready), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rdata(d_rdata), .d_rdata_valid(d_rdata_valid),
    .mem_cmd(mem_cmd), .mem_cmd_ready(mem_cmd_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  memory_arbiter #(.ROUND_ROBIN(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .i_cmd(i_cmd0), .i_cmd_ready(i_ready0), .i_addr(i_addr),
    .i_rdata(i_rdata0), .i_rdata_valid(i_valid0),
    .d_cmd(d_cmd0), .d_cmd_ready(d_ready0), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rdata(d_rdata0), .d_rdata_valid(d_valid0),
    .mem_cmd(mem_cmd0), .mem_cmd_ready(1'b1), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_wmask(mem_wmask0),
    .mem_rdata(mem_rdata), .mem_rdata_valid(1'b1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_i_valid"}, i_rdata_valid, 1'b0);
    chk1({tag, "_d_valid"}, d_rdata_valid, 1'b0);
  endtask

  // one complete transaction: request, optional stall, issue, optional read return
  task automatic run_txn(input logic [2:0] ic, input logic [31:0] ia, input logic [2:0] dc,
                         input logic [31:0] da, input logic [31:0] wd, input logic [31:0] wm,
                         input int stall, input int lat, input logic [31:0] rd);
    bit w;
    logic [2:0] ec;
    logic [31:0] ea;
    i_cmd = ic; i_addr = ia; d_cmd = dc; d_addr = da; d_wdata = wd; d_wmask = wm;
    mem_cmd_ready = 1'b0; mem_rdata_valid = 1'b0;
    #1;
    if (ic != MEMORY_CMD_READ && dc == MEMORY_CMD_NOP) begin
      chk1("noreq_i_ready", i_cmd_ready, 1'b1);
      chk1("noreq_d_ready", d_cmd_ready, 1'b1);
      mem_rdata_valid = 1'($urandom);
      step;
      i_cmd = MEMORY_CMD_NOP; mem_rdata_valid = 1'b0;
      #1;
      chk("noreq_mem_cmd", 32'(mem_cmd), 32'(MEMORY_CMD_NOP));
      chk_quiet("noreq");
      return;
    end
    w = (ic == MEMORY_CMD_READ && dc != MEMORY_CMD_NOP) ? !last_win : (dc != MEMORY_CMD_NOP);
    chk1("grant_i_ready", i_cmd_ready, !w);
    chk1("grant_d_ready", d_cmd_ready, w);
    last_win = w;
    ec = w ? dc : MEMORY_CMD_READ;
    ea = w ? da : ia;
    step;
    i_cmd = MEMORY_CMD_NOP; d_cmd = MEMORY_CMD_NOP;
    for (int k = 0; k <= stall; k++) begin
      mem_cmd_ready = (k == stall);
      mem_rdata_valid = 1'($urandom);
      #1;
      chk("issue_cmd", 32'(mem_cmd), 32'(ec));
      chk("issue_addr", mem_addr, ea);
      if (w) begin
        chk("issue_wdata", mem_wdata, wd);
        chk("issue_wmask", mem_wmask, wm);
      end
      chk1("issue_i_ready", i_cmd_ready, 1'b0);
      chk1("issue_d_ready", d_cmd_ready, 1'b0);
      step;
    end
    mem_cmd_ready = 1'b0;
    if (ec == MEMORY_CMD_WRITE) begin
      mem_rdata_valid = 1'b0;
      #1;
      chk("wr_done_cmd", 32'(mem_cmd), 32'(MEMORY_CMD_NOP));
      chk1("wr_done_d_ready", d_cmd_ready, 1'b1);
      chk_quiet("wr_done");
      return;
    end
    for (int k = 0; k <= lat; k++) begin
      mem_rdata_valid = (k == lat);
      mem_rdata = (k == lat) ? rd : $urandom;
      #1;
      chk("wait_cmd", 32'(mem_cmd), 32'(MEMORY_CMD_NOP));
      chk1("wait_i_ready", i_cmd_ready, 1'b0);
      chk_quiet("wait");
      step;
    end
    mem_rdata_valid = 1'b0;
    mem_rdata = $urandom;
    #1;
    if (w) m_drdata = rd; else m_irdata = rd;
    chk1("rd_i_valid", i_rdata_valid, !w);
    chk1("rd_d_valid", d_rdata_valid, w);
    chk("rd_i_rdata", i_rdata, m_irdata);
    chk("rd_d_rdata", d_rdata, m_drdata);
    chk1("rd_i_ready", i_cmd_ready, 1'b1);
    step;
    #1;
    chk_quiet("rd_after");
  endtask

  initial begin
    reset = 1'b1;
    i_cmd = MEMORY_CMD_NOP; d_cmd = MEMORY_CMD_NOP; i_cmd0 = MEMORY_CMD_NOP; d_cmd0 = MEMORY_CMD_NOP;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    mem_cmd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
    last_win = 1'b0; m_irdata = '0; m_drdata = '0;
    step;
    step;
    reset = 1'b0;
    #1;
    chk1("rst_i_valid", i_rdata_valid, 1'b0);
    chk1("rst_d_valid", d_rdata_valid, 1'b0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_mem_cmd", 32'(mem_cmd), 32'(MEMORY_CMD_NOP));
    chk1("rst_i_ready", i_cmd_ready, 1'b1);
    chk1("rst_d_ready", d_cmd_ready, 1'b1);
    // fixed-priority instance: data must win every tie
    for (int r = 0; r < 2; r++) begin
      i_cmd0 = MEMORY_CMD_READ; d_cmd0 = MEMORY_CMD_READ;
      #1;
      chk1("fixed_tie_d_ready", d_ready0, 1'b1);
      chk1("fixed_tie_i_ready", i_ready0, 1'b0);
      step;
      i_cmd0 = MEMORY_CMD_NOP; d_cmd0 = MEMORY_CMD_NOP;
      repeat (4) step;
    end
    // round-robin ties: data first after reset, then instruction
    run_txn(MEMORY_CMD_READ, 32'h40, MEMORY_CMD_READ, 32'h80, 32'h0, 32'h0, 0, 1, 32'hA5A5_0001);
    run_txn(MEMORY_CMD_READ, 32'h44, MEMORY_CMD_READ, 32'h84, 32'h0, 32'h0, 0, 0, 32'hA5A5_0002);
    run_txn(MEMORY_CMD_NOP, 32'h0, MEMORY_CMD_WRITE, 32'h100, 32'hDEAD_BEEF, 32'h0000_00FF, 0, 0, 32'h0);
    run_txn(MEMORY_CMD_READ, 32'h0, MEMORY_CMD_NOP, 32'h0, 32'h0, 32'h0, 0, 2, 32'h0000_0013);
    run_txn(MEMORY_CMD_NOP, 32'h0, MEMORY_CMD_WRITE, 32'h200, 32'h1234_5678, 32'hFFFF_0000, 5, 0, 32'h0);
    run_txn(MEMORY_CMD_WRITE, 32'h300, MEMORY_CMD_NOP, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
    // reset while waiting for read data discards the pending read
    i_cmd = MEMORY_CMD_READ; i_addr = 32'h500;
    step;
    i_cmd = MEMORY_CMD_NOP; mem_cmd_ready = 1'b1;
    step;
    mem_cmd_ready = 1'b0; reset = 1'b1;
    step;
    reset = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    step;
    mem_rdata_valid = 1'b0;
    last_win = 1'b0; m_irdata = '0; m_drdata = '0;
    #1;
    chk_quiet("stale");
    chk1("stale_i_ready", i_cmd_ready, 1'b1);
    chk1("stale_d_ready", d_cmd_ready, 1'b1);
    chk("stale_mem_cmd", 32'(mem_cmd), 32'(MEMORY_CMD_NOP));
    chk("stale_i_rdata", i_rdata, 32'h0);
    step;
    for (int n = 0; n < 40; n++)
      run_txn(3'($urandom_range(0, 2)), $urandom, 3'($urandom_range(0, 2)), $urandom, $urandom,
              $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
